// File: rtl/prbs_checker_parallel_fab.sv
// Parallel PRBS checker (x^POLY2 + x^(POLY2-POLY1) + 1, default PRBS7).
// Receive-side partner of the parallel PRBS generator. Self-synchronises on the
// incoming stream, declares lock after LOCK_CNT consecutive clean words, then
// checks each word against a free-running reference and counts bit errors.
//
// Ports:
//   clk_i         clock, all logic on rising edge
//   reset_i       synchronous, active-high reset
//   clear_i       clears err_cnt_o / err_sticky_o (lock state untouched)
//   data_valid_i  qualifies data_i; no state change when low
//   data_i        received word, bit NBITS-1 first on the wire
//   lock_o        checker locked to the PRBS stream
//   err_o         1-cycle pulse: last valid word (while locked) had bit errors
//   err_sticky_o  set on any err_o, held until clear_i / reset_i
//   err_cnt_o     saturating count of errored bits while locked
module prbs_checker_parallel_fab #(
    parameter int unsigned NBITS      = 8,
    parameter int unsigned POLY2      = 7,
    parameter int unsigned POLY1      = 1,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 data_valid_i,
    input  logic [NBITS-1:0]     data_i,
    output logic                 lock_o,
    output logic                 err_o,
    output logic                 err_sticky_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BadW  = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned NerrW = $clog2(NBITS + 1);
    // One spare bit so the sum can never wrap before the saturation test.
    localparam int unsigned SumW  = ((ERR_CNT_W > NerrW) ? ERR_CNT_W : NerrW) + 1;
    localparam logic [SumW-1:0] CntMax = SumW'({ERR_CNT_W{1'b1}});

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    // Next word of the sequence: extend the last POLY2 bits of w by NBITS bits.
    function automatic logic [NBITS-1:0] prbs_next(input logic [NBITS-1:0] w);
        logic [NBITS+POLY2-1:0] s;
        s = '0;
        s[NBITS+POLY2-1:NBITS] = w[POLY2-1:0];
        for (int i = int'(NBITS) - 1; i >= 0; i--) begin
            s[i] = s[i+POLY2] ^ s[i+POLY2-POLY1];
        end
        return s[NBITS-1:0];
    endfunction

    function automatic logic [NerrW-1:0] popcount(input logic [NBITS-1:0] v);
        logic [NerrW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NBITS); i++) begin
            c = c + NerrW'(v[i]);
        end
        return c;
    endfunction

    state_e                 state_q, state_d;
    logic                   seeded_q, seeded_d;
    logic [GoodW-1:0]       good_cnt_q, good_cnt_d;
    logic [BadW-1:0]        bad_cnt_q, bad_cnt_d;
    // In SEARCH holds the previous valid word; in LOCKED the free-running reference.
    logic [NBITS-1:0]       ref_q, ref_d;
    logic                   err_q, err_d;
    logic                   sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;

    logic [NBITS-1:0]       expected;
    logic [NerrW-1:0]       nerr;
    logic [SumW-1:0]        cnt_sum;
    logic [ERR_CNT_W-1:0]   cnt_sat;
    logic [GoodW-1:0]       good_inc;
    logic [BadW-1:0]        bad_inc;

    assign expected = prbs_next(ref_q);
    assign nerr     = popcount(data_i ^ expected);
    assign cnt_sum  = SumW'(cnt_q) + SumW'(nerr);
    assign cnt_sat  = (cnt_sum > CntMax) ? {ERR_CNT_W{1'b1}} : cnt_sum[ERR_CNT_W-1:0];
    assign good_inc = good_cnt_q + GoodW'(1);
    assign bad_inc  = bad_cnt_q + BadW'(1);

    always_comb begin
        state_d    = state_q;
        seeded_d   = seeded_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        ref_d      = ref_q;
        err_d      = 1'b0;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;

        if (data_valid_i) begin
            unique case (state_q)
                StSearch: begin
                    ref_d    = data_i;
                    seeded_d = 1'b1;
                    // First word after reset/unlock only seeds the comparison.
                    if (seeded_q) begin
                        // All-zero words never count, so a dead link cannot lock.
                        if ((data_i == expected) && (data_i != '0)) begin
                            good_cnt_d = good_inc;
                            if (good_inc == GoodW'(LOCK_CNT)) begin
                                state_d   = StLocked;
                                bad_cnt_d = '0;
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                end
                StLocked: begin
                    // Reference advances on its own so one flipped bit counts once.
                    ref_d = expected;
                    if (nerr != '0) begin
                        err_d     = 1'b1;
                        sticky_d  = 1'b1;
                        cnt_d     = cnt_sat;
                        bad_cnt_d = bad_inc;
                        if (bad_inc == BadW'(UNLOCK_CNT)) begin
                            state_d    = StSearch;
                            seeded_d   = 1'b0;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end
                    end else begin
                        bad_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        if (clear_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StSearch;
            seeded_q   <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            ref_q      <= '0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            seeded_q   <= seeded_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            ref_q      <= ref_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign lock_o       = (state_q == StLocked);
    assign err_o        = err_q;
    assign err_sticky_o = sticky_q;
    assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_prbs_checker_parallel_fab.sv
module tb_prbs_checker_parallel_fab;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        lock, err, sticky;
    logic [15:0] cnt;
    logic        lock4, err4, sticky4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    prbs_checker_parallel_fab #(
        .NBITS(8), .POLY2(7), .POLY1(1), .LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(16)
    ) dut (
        .clk_i(clk), .reset_i(reset), .clear_i(clr), .data_valid_i(vld), .data_i(din),
        .lock_o(lock), .err_o(err), .err_sticky_o(sticky), .err_cnt_o(cnt)
    );

    prbs_checker_parallel_fab #(
        .NBITS(8), .POLY2(7), .POLY1(1), .LOCK_CNT(16), .UNLOCK_CNT(4), .ERR_CNT_W(4)
    ) dut4 (
        .clk_i(clk), .reset_i(reset), .clear_i(clr), .data_valid_i(vld), .data_i(din),
        .lock_o(lock4), .err_o(err4), .err_sticky_o(sticky4), .err_cnt_o(cnt4)
    );

    typedef struct {
        logic lock;
        logic err;
        logic sticky;
        int   cnt;
        int   cnt4;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference sequence as a serial bit stream: b[n] = b[n-7] ^ b[n-6].
    function automatic logic [7:0] p_next(input logic [7:0] w);
        bit         q[$];
        logic [7:0] r;
        for (int i = 7; i >= 0; i--) q.push_back(w[i]);
        for (int k = 0; k < 8; k++) q.push_back(q[q.size()-7] ^ q[q.size()-6]);
        r = 8'h00;
        for (int k = 0; k < 8; k++) r = {r[6:0], q[8+k]};
        return r;
    endfunction

    // Behavioural model state
    bit         m_locked, m_seeded, m_err, m_sticky;
    int         m_good, m_bad, m_cnt, m_cnt4;
    logic [7:0] m_prev, m_ref;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model(input bit r, input bit c, input bit v, input logic [7:0] d);
        int n;
        logic [7:0] e;
        if (r) begin
            m_locked = 0; m_seeded = 0; m_err = 0; m_sticky = 0;
            m_good = 0; m_bad = 0; m_cnt = 0; m_cnt4 = 0; m_prev = 0; m_ref = 0;
            return;
        end
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (!m_seeded) begin
                    m_seeded = 1;
                    m_good = 0;
                end else begin
                    if (d == p_next(m_prev) && d != 8'h00) m_good++;
                    else m_good = 0;
                    if (m_good == 16) begin
                        m_locked = 1;
                        m_ref = d;
                        m_bad = 0;
                    end
                end
                m_prev = d;
            end else begin
                e = p_next(m_ref);
                m_ref = e;
                n = $countones(d ^ e);
                if (n > 0) begin
                    m_err = 1;
                    m_sticky = 1;
                    m_cnt = sat(m_cnt + n, 65535);
                    m_cnt4 = sat(m_cnt4 + n, 15);
                    m_bad++;
                    if (m_bad == 4) begin
                        m_locked = 0; m_seeded = 0; m_good = 0; m_bad = 0;
                    end
                end else begin
                    m_bad = 0;
                end
            end
        end
        if (c) begin
            m_cnt = 0; m_cnt4 = 0; m_sticky = 0;
        end
    endtask

    task automatic step(input bit r, input bit c, input bit v, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        reset = r; clr = c; vld = v; din = d;
        model(r, c, v, d);
        e.lock = m_locked; e.err = m_err; e.sticky = m_sticky; e.cnt = m_cnt; e.cnt4 = m_cnt4;
        sb.push_back(e);
    endtask

    // Wait for the edge that samples the last driven word, then settle.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: outputs are registered, so every edge presents a result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_lock", lock, e.lock);
            chk("sb_err", err, e.err);
            chk("sb_sticky", sticky, e.sticky);
            chk("sb_cnt", cnt, e.cnt);
            chk("sb_cnt4", cnt4, e.cnt4);
            chk("sb_lock4", lock4, e.lock);
        end
    end

    logic [7:0] g;

    task automatic golden(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, g);
            g = p_next(g);
        end
    endtask

    initial begin
        // 1: reset and lock on golden stream from 0xFF
        step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'h5A);
        after_edge();
        chk("reset_lock", lock, 0);
        chk("reset_cnt", cnt, 0);
        chk("reset_sticky", sticky, 0);
        g = 8'hFF;
        golden(1);
        chk("golden_second", g, 8'h02);
        golden(15);
        after_edge();
        chk("lock_not_yet", lock, 0);
        golden(1);
        after_edge();
        chk("lock_after17", lock, 1);
        chk("cnt_clean", cnt, 0);

        // 2: single bit error
        golden(5);
        step(0, 0, 1, g ^ 8'h08);
        g = p_next(g);
        after_edge();
        chk("single_err", err, 1);
        chk("single_cnt", cnt, 1);
        chk("single_sticky", sticky, 1);
        chk("single_lock", lock, 1);
        golden(10);
        after_edge();
        chk("no_multiply", cnt, 1);
        chk("err_gone", err, 0);

        // 3: four inverted words lose lock, then relock
        step(0, 1, 1, g);
        g = p_next(g);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, ~g);
            g = p_next(g);
            if (i == 2) begin
                after_edge();
                chk("lock_held3", lock, 1);
            end
        end
        after_edge();
        chk("unlock_after4", lock, 0);
        chk("cnt32", cnt, 32);
        chk("cnt4_sat", cnt4, 15);
        golden(16);
        after_edge();
        chk("relock_not_yet", lock, 0);
        golden(1);
        after_edge();
        chk("relock17", lock, 1);

        // 4: constant idle patterns
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 8'h00);
        after_edge();
        chk("zero_nolock", lock, 0);
        for (int i = 0; i < 30; i++) step(0, 0, 1, 8'hA5);
        after_edge();
        chk("a5_nolock", lock, 0);
        chk("a5_cnt", cnt, 0);

        // 5: clear vs error in same cycle, 4-bit saturation
        step(1, 0, 0, 8'h00);
        g = 8'h3C;
        golden(17);
        step(0, 1, 1, g ^ 8'h10);
        g = p_next(g);
        after_edge();
        chk("clr_err", err, 1);
        chk("clr_sticky", sticky, 0);
        chk("clr_cnt", cnt, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, g ^ (8'h01 << (i % 8)));
            g = p_next(g);
            golden(1);
        end
        after_edge();
        chk("sat_cnt4", cnt4, 15);
        chk("sat_cnt16", cnt, 20);
        chk("sat_lock", lock, 1);

        // 6: random valid gaps, random errors and clears
        step(1, 0, 0, 8'h00);
        g = 8'($urandom_range(1, 255));
        for (int nv = 0; nv < 17;) begin
            if ($urandom_range(0, 2) == 0) begin
                step(0, 0, 0, 8'($urandom));
            end else begin
                step(0, 0, 1, g);
                g = p_next(g);
                nv++;
            end
        end
        after_edge();
        chk("gap_lock", lock, 1);
        chk("gap_cnt", cnt, 0);
        for (int i = 0; i < 300; i++) begin
            bit v, c;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 24) == 0);
            if (v) begin
                d = g;
                if ($urandom_range(0, 7) == 0) d = d ^ (8'h01 << $urandom_range(0, 7));
                g = p_next(g);
            end else begin
                d = 8'($urandom);
            end
            step(0, c, v, d);
        end
        golden(17);
        after_edge();
        chk("rand_relock", lock, 1);
        step(1, 0, 1, g);
        after_edge();
        chk("rst_lock", lock, 0);
        chk("rst_err", err, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_cnt", cnt, 0);
        golden(8);
        step(0, 0, 0, 8'h77);
        golden(8);
        after_edge();
        chk("rst_relock_not_yet", lock, 0);
        golden(1);
        after_edge();
        chk("rst_relock17", lock, 1);

        step(0, 0, 0, 8'h00);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
